// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results wait in a small FIFO and are forced through when starved too long.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wen,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic [DATA_W-1:0] ll_data,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              query_hit,
  output logic [CNT_W-1:0]  q_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int STV_W = $clog2(MAX_WAIT + 1);

  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_PIPE,
    GRANT_QUEUE,
    GRANT_FORCE
  } grant_e;

  logic [ADDR_W-1:0]     q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]     q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_valid;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [STV_W-1:0]      starve_cnt;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  grant_e            grant;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign ll_ready  = !full && !rst;
  assign push      = ll_valid && ll_ready;
  assign head_addr = q_addr[rd_ptr];
  assign head_data = q_data[rd_ptr];
  assign q_count   = count;

  always_comb begin
    grant = GRANT_IDLE;
    if (!rst) begin
      if (starve_cnt == STARVE_MAX && !empty) grant = GRANT_FORCE;
      else if (pipe_wen)                      grant = GRANT_PIPE;
      else if (!empty)                        grant = GRANT_QUEUE;
    end
  end

  assign pop = (grant == GRANT_QUEUE) || (grant == GRANT_FORCE);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    rf_wen     = 1'b0;
    rf_addr    = pipe_addr;
    rf_data    = pipe_data;
    pipe_stall = 1'b0;
    unique case (grant)
      GRANT_PIPE: rf_wen = (pipe_addr != '0);
      GRANT_QUEUE, GRANT_FORCE: begin
        rf_addr    = head_addr;
        rf_data    = head_data;
        rf_wen     = (head_addr != '0);
        pipe_stall = (grant == GRANT_FORCE) && pipe_wen;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      q_valid    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;

      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (pop || empty)                  starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;

      // Push and pop never target the same slot: that needs a queue both empty and full.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (pop  && rd_ptr == PTR_W'(i)) q_valid[i] <= 1'b0;
        if (push && wr_ptr == PTR_W'(i)) q_valid[i] <= 1'b1;
      end
    end
  end

  // NOTE: payload storage carries no reset; q_valid and count alone decide
  // which slots mean anything.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= ll_addr;
      q_data[wr_ptr] <= ll_data;
    end
  end

  always_comb begin
    query_hit = 1'b0;
    if (!rst && query_addr != '0) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (q_valid[i] && q_addr[i] == query_addr) query_hit = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, well before the next rising edge.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wen;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_addr;
  logic [31:0] ll_data;
  logic        rf_wen;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  query_addr;
  logic        query_hit;
  logic [1:0]  q_count;

  int n_vec = 0;
  int n_err = 0;

  wb_port_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(2), .MAX_WAIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
    .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_data(rf_data),
    .query_addr(query_addr), .query_hit(query_hit), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pipe(input logic w, input logic [4:0] a, input logic [31:0] d);
    pipe_wen  = w;
    pipe_addr = a;
    pipe_data = d;
  endtask

  task automatic ll(input logic v, input logic [4:0] a, input logic [31:0] d);
    ll_valid = v;
    ll_addr  = a;
    ll_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pipe(0, 0, 0);
    ll(0, 0, 0);
    query_addr = 0;

    // reset: outputs quiet even with active requests
    @(negedge clk); #1;
    check("rst_ll_ready", ll_ready, 0);
    check("rst_rf_wen", rf_wen, 0);
    ll(1, 3, 32'h33); pipe(1, 4, 32'h44); query_addr = 3; #1;
    check("rst_rf_wen_busy", rf_wen, 0);
    check("rst_stall", pipe_stall, 0);
    check("rst_ll_ready_busy", ll_ready, 0);
    check("rst_query_hit", query_hit, 0);
    @(negedge clk); #1;
    check("rst_q_count", q_count, 0);
    rst = 1'b0; pipe(0, 0, 0); ll(0, 0, 0); query_addr = 0; #1;
    check("post_rst_ll_ready", ll_ready, 1);
    check("post_rst_rf_wen", rf_wen, 0);

    // 1: queued write drains into an idle slot
    @(negedge clk); ll(1, 7, 32'h1234); #1;
    check("t1_ready", ll_ready, 1);
    check("t1_idle_wen", rf_wen, 0);
    @(negedge clk); ll(0, 0, 0); #1;
    check("t1_q_count1", q_count, 1);
    check("t1_wen", rf_wen, 1);
    check("t1_addr", rf_addr, 7);
    check("t1_data", rf_data, 32'h1234);
    @(negedge clk); #1;
    check("t1_q_count0", q_count, 0);
    check("t1_wen_after", rf_wen, 0);

    // 2: starvation forces a queued write after four pipeline grants
    @(negedge clk); pipe(1, 1, 32'h11); ll(1, 9, 32'haaaa); #1;
    check("t2_push_cycle_addr", rf_addr, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); ll(0, 0, 0); pipe(1, 5'(2 + i), 32'h100 + 32'(i)); #1;
      check("t2_pipe_addr", rf_addr, 32'(2 + i));
      check("t2_pipe_data", rf_data, 32'h100 + 32'(i));
      check("t2_pipe_stall", pipe_stall, 0);
    end
    @(negedge clk); pipe(1, 6, 32'h66); #1;
    check("t2_force_addr", rf_addr, 9);
    check("t2_force_data", rf_data, 32'haaaa);
    check("t2_force_wen", rf_wen, 1);
    check("t2_force_stall", pipe_stall, 1);
    @(negedge clk); #1;
    check("t2_retry_addr", rf_addr, 6);
    check("t2_retry_data", rf_data, 32'h66);
    check("t2_retry_stall", pipe_stall, 0);
    check("t2_q_count", q_count, 0);

    // 3: full queue back-pressure, not pop-aware, order preserved
    @(negedge clk); pipe(1, 1, 32'h1); ll(1, 10, 32'ha0); #1;
    check("t3_ready0", ll_ready, 1);
    @(negedge clk); ll(1, 11, 32'hb0); #1;
    check("t3_ready1", ll_ready, 1);
    @(negedge clk); ll(1, 12, 32'hc0); #1;
    check("t3_full_ready", ll_ready, 0);
    check("t3_full_count", q_count, 2);
    repeat (2) begin
      @(negedge clk); #1;
      check("t3_wait_ready", ll_ready, 0);
      check("t3_wait_addr", rf_addr, 1);
    end
    @(negedge clk); #1;
    check("t3_force_addr", rf_addr, 10);
    check("t3_force_data", rf_data, 32'ha0);
    check("t3_force_stall", pipe_stall, 1);
    check("t3_pop_cycle_ready", ll_ready, 0);
    @(negedge clk); #1;
    check("t3_after_pop_ready", ll_ready, 1);
    check("t3_after_pop_count", q_count, 1);
    check("t3_after_pop_addr", rf_addr, 1);
    @(negedge clk); ll(0, 0, 0); pipe(0, 0, 0); #1;
    check("t3_drain1_addr", rf_addr, 11);
    check("t3_drain1_data", rf_data, 32'hb0);
    check("t3_drain1_count", q_count, 2);
    @(negedge clk); #1;
    check("t3_drain2_addr", rf_addr, 12);
    check("t3_drain2_data", rf_data, 32'hc0);
    check("t3_drain2_wen", rf_wen, 1);
    @(negedge clk); #1;
    check("t3_empty_count", q_count, 0);
    check("t3_empty_wen", rf_wen, 0);

    // 4: writes to x0 are suppressed, queued x0 still consumed
    @(negedge clk); ll(1, 0, 32'hdead); #1;
    check("t4_push_wen", rf_wen, 0);
    @(negedge clk); ll(0, 0, 0); #1;
    check("t4_head_count", q_count, 1);
    check("t4_head_wen", rf_wen, 0);
    check("t4_head_data", rf_data, 32'hdead);
    @(negedge clk); pipe(1, 0, 32'h55); #1;
    check("t4_popped_count", q_count, 0);
    check("t4_pipe_x0_wen", rf_wen, 0);
    check("t4_pipe_x0_stall", pipe_stall, 0);

    // 5: hazard query
    @(negedge clk); pipe(1, 3, 32'h33); ll(1, 5, 32'h55); query_addr = 5; #1;
    check("t5_same_cycle_push", query_hit, 0);
    @(negedge clk); ll(0, 0, 0); #1;
    check("t5_hit_r5", query_hit, 1);
    query_addr = 6; #1;
    check("t5_miss_r6", query_hit, 0);
    query_addr = 0; #1;
    check("t5_miss_r0", query_hit, 0);
    query_addr = 5;
    @(negedge clk); pipe(0, 0, 0); #1;
    check("t5_pop_cycle_hit", query_hit, 1);
    check("t5_pop_addr", rf_addr, 5);
    @(negedge clk); #1;
    check("t5_after_pop_hit", query_hit, 0);
    check("t5_after_pop_count", q_count, 0);

    // 6: reset discards queued entries
    @(negedge clk); pipe(1, 1, 32'h1); ll(1, 20, 32'h2020);
    @(negedge clk); ll(1, 21, 32'h2121);
    @(negedge clk); ll(0, 0, 0); pipe(0, 0, 0); rst = 1'b1; query_addr = 20; #1;
    check("t6_pre_count", q_count, 2);
    check("t6_rst_wen", rf_wen, 0);
    check("t6_rst_ready", ll_ready, 0);
    check("t6_rst_hit", query_hit, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("t6_count", q_count, 0);
    check("t6_wen", rf_wen, 0);
    check("t6_ready", ll_ready, 1);
    check("t6_hit", query_hit, 0);
    @(negedge clk); #1;
    check("t6_idle_wen", rf_wen, 0);
    check("t6_idle_count", q_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
